// File: rtl/lib_arbiter_pkg.sv
// Shared types for the pixel-group scheduler.
// sched_state_t : scheduler FSM state encoding.
// evt_t         : event payload {grp, x, y} at the default geometry
//                 (4 groups, 1-bit row/column address).
package lib_arbiter_pkg;

  localparam int unsigned EVT_GRP_W = 2;
  localparam int unsigned EVT_LVL_W = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    SERVE   = 2'd2,
    RELEASE = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [EVT_GRP_W-1:0] grp;
    logic [EVT_LVL_W-1:0] x;
    logic [EVT_LVL_W-1:0] y;
  } evt_t;

  localparam int unsigned EVT_W = $bits(evt_t);

endpackage

// File: rtl/evt_fifo.sv
// Event buffer: synchronous FIFO with first-word-fall-through head.
// Ports:
//   clk_i, reset_i     : clock, synchronous active-low reset
//   push_i, data_i     : write request and payload (ignored when full
//                        unless a pop happens in the same cycle)
//   pop_i              : read request (ignored when empty)
//   full_o, empty_o    : occupancy flags
//   head_o             : oldest entry, valid while empty_o is low
// DEPTH must be a power of 2 (>= 2) so the pointers wrap naturally.
module evt_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot the push needs.
  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

endmodule

// File: rtl/group_scheduler.sv
// Round-robin scheduler that serves one pixel group at a time and
// funnels its granted pixel addresses into a shared event FIFO.
// Ports:
//   clk_i, reset_i            : clock, synchronous active-low reset
//   grp_req_i                 : per-group pending request
//   grp_active_i              : per-group "grant valid this cycle"
//   grp_release_i             : per-group "all requests served"
//   grp_x_add_i, grp_y_add_i  : per-group granted row / column (flattened)
//   grp_enable_o              : one-hot enable to the group being served
//   evt_valid_o, evt_ready_i  : event handshake
//   evt_grp_o, evt_x_o, evt_y_o : event payload (FIFO head)
//   busy_o                    : FSM not in IDLE
//   ovf_o                     : sticky, set when an event was dropped
//   drop_cnt_o                : saturating dropped-event count, present
//                               only when GRP_SCHED_DROP_CNT_EN is defined
module group_scheduler
  import lib_arbiter_pkg::*;
#(
  parameter int unsigned NUM_GROUPS = 4,
  parameter int unsigned GRP_ADD    = 2,
  parameter int unsigned Lvl_ADD    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_GROUPS-1:0]         grp_req_i,
  input  logic [NUM_GROUPS-1:0]         grp_active_i,
  input  logic [NUM_GROUPS-1:0]         grp_release_i,
  input  logic [NUM_GROUPS*Lvl_ADD-1:0] grp_x_add_i,
  input  logic [NUM_GROUPS*Lvl_ADD-1:0] grp_y_add_i,
  output logic [NUM_GROUPS-1:0]         grp_enable_o,
  output logic                          evt_valid_o,
  input  logic                          evt_ready_i,
  output logic [GRP_ADD-1:0]            evt_grp_o,
  output logic [Lvl_ADD-1:0]            evt_x_o,
  output logic [Lvl_ADD-1:0]            evt_y_o,
  output logic                          busy_o,
`ifdef GRP_SCHED_DROP_CNT_EN
  output logic [7:0]                    drop_cnt_o,
`endif
  output logic                          ovf_o
);

  localparam int unsigned EW = GRP_ADD + 2 * Lvl_ADD;

  sched_state_t          state_q, state_d;
  logic [GRP_ADD-1:0]    sel_q, sel_d;
  logic [GRP_ADD-1:0]    rr_q, rr_d;
  logic [GRP_ADD-1:0]    pick, idx;
  logic                  found;
  logic                  push, pop, drop;
  logic                  fifo_full, fifo_empty;
  logic [EW-1:0]         push_data, head;
  logic [NUM_GROUPS-1:0] en_q, en_d;
  logic                  busy_q, ovf_q;

  // Next-state logic; the round-robin search starts at rr_q and wraps.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    push    = 1'b0;
    found   = 1'b0;
    pick    = '0;
    idx     = '0;
    for (int i = 0; i < int'(NUM_GROUPS); i++) begin
      idx = GRP_ADD'((int'(rr_q) + i) % int'(NUM_GROUPS));
      if (!found && grp_req_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    case (state_q)
      IDLE: begin
        if (|grp_req_i) state_d = SELECT;
      end
      SELECT: begin
        if (found) begin
          sel_d   = pick;
          state_d = SERVE;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE: begin
        push = grp_active_i[sel_q];
        if (grp_release_i[sel_q]) state_d = RELEASE;
      end
      RELEASE: begin
        rr_d    = GRP_ADD'((int'(sel_q) + 1) % int'(NUM_GROUPS));
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Enable and busy are registered from the next state so they line up
  // with the state they describe.
  always_comb begin
    en_d = '0;
    if (state_d == SERVE) en_d = NUM_GROUPS'(1) << sel_d;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      en_q    <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      en_q    <= en_d;
      busy_q  <= (state_d != IDLE);
      ovf_q   <= ovf_q | drop;
    end
  end

  assign push_data = {sel_q,
                      grp_x_add_i[int'(sel_q)*Lvl_ADD +: Lvl_ADD],
                      grp_y_add_i[int'(sel_q)*Lvl_ADD +: Lvl_ADD]};
  assign pop  = !fifo_empty && evt_ready_i;
  assign drop = push && fifo_full && !pop;

  evt_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

`ifdef GRP_SCHED_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  // Saturating count of dropped events.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

  assign grp_enable_o = en_q;
  assign busy_o       = busy_q;
  assign ovf_o        = ovf_q;
  assign evt_valid_o  = !fifo_empty;
  assign evt_grp_o    = head[EW-1 -: GRP_ADD];
  assign evt_x_o      = head[2*Lvl_ADD-1 -: Lvl_ADD];
  assign evt_y_o      = head[Lvl_ADD-1:0];

endmodule

// File: tb/tb_group_scheduler.sv
// Self-checking bench for group_scheduler (4 groups, 1-bit addresses,
// 4-entry FIFO). Expected events go into a scoreboard queue as they are
// driven and are compared when the DUT presents them with ready high.
module tb_group_scheduler;
  import lib_arbiter_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [3:0] grp_req, grp_act, grp_rel, grp_x, grp_y;
  logic [3:0] grp_enable;
  logic       evt_valid, evt_ready;
  logic [1:0] evt_grp;
  logic       evt_x, evt_y;
  logic       busy, ovf;
`ifdef GRP_SCHED_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  group_scheduler #(
    .NUM_GROUPS(4), .GRP_ADD(2), .Lvl_ADD(1), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .grp_req_i    (grp_req),
    .grp_active_i (grp_act),
    .grp_release_i(grp_rel),
    .grp_x_add_i  (grp_x),
    .grp_y_add_i  (grp_y),
    .grp_enable_o (grp_enable),
    .evt_valid_o  (evt_valid),
    .evt_ready_i  (evt_ready),
    .evt_grp_o    (evt_grp),
    .evt_x_o      (evt_x),
    .evt_y_o      (evt_y),
    .busy_o       (busy),
`ifdef GRP_SCHED_DROP_CNT_EN
    .drop_cnt_o   (drop_cnt),
`endif
    .ovf_o        (ovf)
  );

  typedef struct {
    logic [3:0] req, act, rel, xv, yv;
    logic       rdy;
    logic [3:0] en;
    logic       bsy;
  } vec_t;

  vec_t tbl[$];
  evt_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic [3:0] cur_en = 4'b0000;
  logic       exp_ovf = 1'b0;
  int         exp_drops = 0;

  function automatic vec_t mk(input logic [3:0] req, act, rel, xv, yv,
                              input logic rdy, input logic [3:0] en,
                              input logic bsy);
    vec_t v;
    v.req = req; v.act = act; v.rel = rel; v.xv = xv; v.yv = yv;
    v.rdy = rdy; v.en = en; v.bsy = bsy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // One clock: drive at posedge+1, check the head at negedge, check
  // registered outputs at the next posedge+1.
  task automatic cyc(input logic [3:0] rq, ac, rl, xv, yv, input logic rd,
                     input logic [3:0] exp_en, input logic exp_busy);
    evt_t e;
    logic pop;
    int   g;
    grp_req = rq; grp_act = ac; grp_rel = rl;
    grp_x = xv; grp_y = yv; evt_ready = rd;
    if (reset_i && cur_en != 4'b0000) begin
      g = 0;
      for (int i = 0; i < 4; i++) if (cur_en[i]) g = i;
      pop = rd && (sb.size() != 0);
      if (ac[g]) begin
        e.grp = 2'(g); e.x = xv[g]; e.y = yv[g];
        if (sb.size() < DEPTH || pop) sb.push_back(e);
        else begin
          exp_ovf = 1'b1;
          if (exp_drops < 255) exp_drops++;
        end
      end
    end
    @(negedge clk);
    if (reset_i && evt_valid && rd) begin
      if (sb.size() == 0) chk("evt_unexpected", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("evt_grp", 32'(evt_grp), 32'(e.grp));
        chk("evt_x", 32'(evt_x), 32'(e.x));
        chk("evt_y", 32'(evt_y), 32'(e.y));
      end
    end
    @(posedge clk); #1;
    if (!reset_i) begin
      sb.delete();
      exp_ovf = 1'b0;
      exp_drops = 0;
    end
    chk("grp_enable", 32'(grp_enable), 32'(exp_en));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("evt_valid", 32'(evt_valid), 32'(sb.size() != 0));
    chk("ovf", 32'(ovf), 32'(exp_ovf));
`ifdef GRP_SCHED_DROP_CNT_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(exp_drops));
`endif
    cur_en = exp_en;
  endtask

  task automatic chk_payload_zero();
    chk("evt_grp_rst", 32'(evt_grp), 32'd0);
    chk("evt_x_rst", 32'(evt_x), 32'd0);
    chk("evt_y_rst", 32'(evt_y), 32'd0);
  endtask

  initial begin
    logic [3:0] oh;
    int order[5] = '{0, 1, 2, 3, 0};

    // Single group 2 (with noise on other groups), then rr pointer probe.
    tbl.push_back(mk(4'b0100, 4'b0000, 4'b0000, 4'h0, 4'h0, 1, 4'b0000, 1));
    tbl.push_back(mk(4'b0100, 4'b0000, 4'b0000, 4'h0, 4'h0, 1, 4'b0100, 1));
    tbl.push_back(mk(4'b0100, 4'b0101, 4'b0001, 4'b0100, 4'b0000, 1, 4'b0100, 1));
    tbl.push_back(mk(4'b0100, 4'b1100, 4'b1000, 4'b0000, 4'b0100, 1, 4'b0100, 1));
    tbl.push_back(mk(4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 1, 4'b0000, 1));
    tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'h0, 4'h0, 1, 4'b0000, 0));
    tbl.push_back(mk(4'b1001, 4'b0000, 4'b0000, 4'h0, 4'h0, 1, 4'b0000, 1));
    tbl.push_back(mk(4'b1001, 4'b0000, 4'b0000, 4'h0, 4'h0, 1, 4'b1000, 1));
    tbl.push_back(mk(4'b1001, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 1, 4'b0000, 1));
    tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'h0, 4'h0, 1, 4'b0000, 0));
    // All groups request; each releases after one event: order 0,1,2,3,0.
    foreach (order[k]) begin
      oh = 4'b0001 << order[k];
      tbl.push_back(mk(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'b0000, 1));
      tbl.push_back(mk(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1, oh, 1));
      tbl.push_back(mk(4'hF, 4'hF, 4'hF, 4'($urandom_range(15)),
                       4'($urandom_range(15)), 1, 4'b0000, 1));
      tbl.push_back(mk(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'b0000, 0));
    end

    reset_i = 1'b0;
    grp_req = '0; grp_act = '0; grp_rel = '0; grp_x = '0; grp_y = '0;
    evt_ready = 1'b0;
    @(posedge clk); #1;
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'b0000, 0);
    chk_payload_zero();
    reset_i = 1'b1;

    foreach (tbl[i])
      cyc(tbl[i].req, tbl[i].act, tbl[i].rel, tbl[i].xv, tbl[i].yv,
          tbl[i].rdy, tbl[i].en, tbl[i].bsy);
    for (int i = 0; i < 3; i++) cyc(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'b0000, 0);

    // Overflow: ready low, five active cycles on group 1, fifth dropped.
    cyc(4'b0010, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'b0000, 1);
    cyc(4'b0010, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'b0010, 1);
    for (int i = 0; i < 4; i++)
      cyc(4'b0010, 4'b0010, 4'h0, 4'($urandom_range(15)), 4'($urandom_range(15)),
          0, 4'b0010, 1);
    cyc(4'b0010, 4'b0010, 4'b0010, 4'hF, 4'hF, 0, 4'b0000, 1);
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'b0000, 0);
    for (int i = 0; i < 6; i++) cyc(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'b0000, 0);
    reset_i = 1'b0;
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'b0000, 0);
    chk_payload_zero();
    reset_i = 1'b1;

    // Full FIFO with simultaneous push and pop: no drop, count stays 4.
    cyc(4'b0001, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'b0000, 1);
    cyc(4'b0001, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'b0001, 1);
    for (int i = 0; i < 4; i++)
      cyc(4'b0001, 4'b0001, 4'h0, 4'($urandom_range(15)), 4'($urandom_range(15)),
          0, 4'b0001, 1);
    cyc(4'b0001, 4'b0001, 4'h0, 4'b0000, 4'b0001, 1, 4'b0001, 1);
    cyc(4'b0001, 4'b0000, 4'b0001, 4'h0, 4'h0, 0, 4'b0000, 1);
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'b0000, 0);
    for (int i = 0; i < 6; i++) cyc(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'b0000, 0);

    // Non-selected activity is ignored; then reset mid-SERVE with 2 buffered.
    cyc(4'b0100, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'b0000, 1);
    cyc(4'b0100, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'b0100, 1);
    cyc(4'b0100, 4'b1011, 4'b1011, 4'hF, 4'hF, 0, 4'b0100, 1);
    cyc(4'b0100, 4'b0100, 4'h0, 4'b0100, 4'b0000, 0, 4'b0100, 1);
    cyc(4'b0100, 4'b0100, 4'h0, 4'b0000, 4'b0100, 0, 4'b0100, 1);
    reset_i = 1'b0;
    cyc(4'b0100, 4'b0100, 4'h0, 4'h0, 4'h0, 0, 4'b0000, 0);
    chk_payload_zero();
    reset_i = 1'b1;
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'b0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/group_scheduler.md
GROUP_SCHEDULER -- requirements
Module: group_scheduler

Interface
REQ-001 SHALL have parameter NUM_GROUPS, default 4, number of pixel groups sharing the event output.
REQ-002 SHALL have parameter GRP_ADD, default 2, group index width, equal to clog2(NUM_GROUPS).
REQ-003 SHALL have parameter Lvl_ADD, default 1, width of the per-group row and column address.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries, a power of 2.
REQ-005 SHALL have port clk_i, input, 1 bit, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_i, input, 1 bit, reset; synchronous, active-low.
REQ-007 SHALL have port grp_req_i, input, NUM_GROUPS bits, per-group pending-request flag.
REQ-008 SHALL have port grp_active_i, input, NUM_GROUPS bits, per-group flag that a pixel grant is valid this cycle.
REQ-009 SHALL have port grp_release_i, input, NUM_GROUPS bits, per-group flag that the group has served all its requests.
REQ-010 SHALL have port grp_x_add_i, input, NUM_GROUPS x Lvl_ADD bits, per-group granted row.
REQ-011 SHALL have port grp_y_add_i, input, NUM_GROUPS x Lvl_ADD bits, per-group granted column.
REQ-012 SHALL have port grp_enable_o, output, NUM_GROUPS bits, one-hot enable to the served group.
REQ-013 SHALL have ports evt_valid_o (output, 1 bit) and evt_ready_i (input, 1 bit), the event handshake.
REQ-014 SHALL have ports evt_grp_o (output, GRP_ADD bits), evt_x_o (output, Lvl_ADD bits) and evt_y_o (output, Lvl_ADD bits), the event payload.
REQ-015 SHALL have outputs busy_o (1 bit, FSM not in IDLE) and ovf_o (1 bit, sticky event-dropped flag).

Function
REQ-016 SHALL implement the FSM states IDLE, SELECT, SERVE and RELEASE.
REQ-017 SHALL move from IDLE to SELECT when any grp_req_i bit is high; otherwise it stays in IDLE.
REQ-018 SHALL, in SELECT, latch sel as the first requesting group at or after rr_ptr (wrapping at NUM_GROUPS-1 to 0), then go to SERVE; if no group still requests, it returns to IDLE.
REQ-019 SHALL drive grp_enable_o[sel] high in SERVE only; all enables are low in every other state.
REQ-020 SHALL, in SERVE, push {sel, grp_x_add_i[sel], grp_y_add_i[sel]} into the FIFO on each cycle where grp_active_i[sel] is 1.
REQ-021 SHALL ignore grp_active_i and grp_release_i bits of groups other than sel.
REQ-022 SHALL go from SERVE to RELEASE on grp_release_i[sel]=1; a push in that same cycle still occurs.
REQ-023 SHALL, in RELEASE, set rr_ptr to (sel+1) mod NUM_GROUPS, hold enables low for that one cycle, then go to IDLE.
REQ-024 SHALL present the FIFO head on evt_* with evt_valid_o high while the FIFO is non-empty; pop occurs when evt_valid_o & evt_ready_i.
REQ-025 SHALL give first-event latency of 1 cycle: a push at edge n into an empty FIFO gives evt_valid_o=1 after edge n.
REQ-026 SHALL, on push to a full FIFO, drop the event and set ovf_o; a simultaneous pop frees space, so the push is accepted and count is unchanged.
REQ-027 SHALL keep ovf_o high until reset.

Reset
REQ-028 SHALL, when reset_i=0 at a clock edge, enter IDLE, set rr_ptr=0 and sel=0, empty the FIFO, and drive grp_enable_o=0, evt_valid_o=0, evt_grp_o/evt_x_o/evt_y_o=0, busy_o=0 and ovf_o=0.
REQ-029 SHALL discard buffered events on reset mid-SERVE and drop the enable on the same edge.

Configuration
REQ-030 SHALL, with GRP_SCHED_DROP_CNT_EN defined, add output drop_cnt_o (8 bits): a count of dropped events, saturating at 255, reset to 0.
REQ-031 SHALL, without GRP_SCHED_DROP_CNT_EN, omit the drop_cnt_o port and counter; only ovf_o reports drops.

Structure
REQ-032 SHALL place sched_state_t (the FSM enum) and the evt_t packed struct {grp, x, y} in lib_arbiter_pkg.
REQ-033 SHALL implement the buffer as sub-module evt_fifo (parameters: width, depth) with push, pop, full, empty and head outputs.

Verification
REQ-034 SHALL test: group 2 alone requests, active 3 cycles, then releases -> grp_enable_o=0100 for 3 cycles, events (2,x,y) x3 in order, rr_ptr=3.
REQ-035 SHALL test: all 4 groups request continuously, each releasing after 1 event -> served order 0,1,2,3,0.
REQ-036 SHALL test: evt_ready_i=0, 5 active cycles with FIFO_DEPTH=4 -> 4 events buffered, ovf_o=1, drop_cnt_o=1 when GRP_SCHED_DROP_CNT_EN is defined.
REQ-037 SHALL test: FIFO full with push and pop in the same cycle -> count stays 4, no drop, ovf_o stays 0.
REQ-038 SHALL test: reset_i=0 mid-SERVE with 2 events buffered -> next cycle grp_enable_o=0, evt_valid_o=0, state IDLE.
REQ-039 SHALL test: grp_active_i on a non-selected group -> no push, no change in the FIFO.
